// File: rtl/ins_hazard_tracker_if.sv
// ----------------------------------------------------------------------------
// ins_hazard_tracker_if
// Bundle between the fetch/ID front end (master) and the hazard tracker
// (slave).
//   id_valid  master->slave  ir holds a valid instruction
//   ir        master->slave  32-bit instruction word
//   flush     master->slave  branch/jump redirect, clears the in-flight window
//   id_ready  slave->master  instruction accepted this cycle (= !stall)
//   opcode/rs/rt/rd/shamt/funct  slave->master  field split of ir
//   ins_class slave->master  one-hot class, bit0..bit4 =
//                            ALUImm, ALUR, Store, Load, Branch
//   fwd_rs/fwd_rt slave->master  0 = register file, k = forward from entry k
//   stall     slave->master  load-use bubble
//   stall_cnt/issue_cnt slave->master  statistics (only with HAZARD_STATS_EN)
// ----------------------------------------------------------------------------
interface ins_hazard_tracker_if #(
  parameter int DEPTH = 3
);
  localparam int FW_W = $clog2(DEPTH + 1);

  logic            id_valid;
  logic            id_ready;
  logic [31:0]     ir;
  logic            flush;
  logic [5:0]      opcode;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      shamt;
  logic [5:0]      funct;
  logic [4:0]      ins_class;
  logic [FW_W-1:0] fwd_rs;
  logic [FW_W-1:0] fwd_rt;
  logic            stall;
`ifdef HAZARD_STATS_EN
  logic [31:0]     stall_cnt;
  logic [31:0]     issue_cnt;

  modport master (
    output id_valid, ir, flush,
    input  id_ready, opcode, rs, rt, rd, shamt, funct, ins_class,
           fwd_rs, fwd_rt, stall, stall_cnt, issue_cnt
  );

  modport slave (
    input  id_valid, ir, flush,
    output id_ready, opcode, rs, rt, rd, shamt, funct, ins_class,
           fwd_rs, fwd_rt, stall, stall_cnt, issue_cnt
  );
`else
  modport master (
    output id_valid, ir, flush,
    input  id_ready, opcode, rs, rt, rd, shamt, funct, ins_class,
           fwd_rs, fwd_rt, stall
  );

  modport slave (
    input  id_valid, ir, flush,
    output id_ready, opcode, rs, rt, rd, shamt, funct, ins_class,
           fwd_rs, fwd_rt, stall
  );
`endif
endinterface

// File: rtl/ins_hazard_tracker.sv
// ----------------------------------------------------------------------------
// ins_hazard_tracker
// ID-stage decode, classification and hazard tracking for the MIPS-subset
// pipeline. Keeps a shift window of the destinations of the last DEPTH issued
// instructions and derives per-source forwarding selects plus a load-use
// stall from it.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : ins_hazard_tracker_if.slave (handshake, ir, decode/hazard outputs)
// Parameters:
//   DEPTH    : in-flight entries tracked after ID (>=1)
//   LOAD_LAT : distance up to which a load result cannot be forwarded yet
//              (1..DEPTH)
// Optional feature macro: HAZARD_STATS_EN adds saturating stall_cnt and
// issue_cnt statistics counters.
// ----------------------------------------------------------------------------
module ins_hazard_tracker #(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ins_hazard_tracker_if.slave  bus
);

  localparam int FW_W = $clog2(DEPTH + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // One-hot class encoding, bit0 = ALUImm ... bit4 = Branch.
  localparam logic [4:0] CLS_ALUIMM = 5'b00001;
  localparam logic [4:0] CLS_ALUR   = 5'b00010;
  localparam logic [4:0] CLS_STORE  = 5'b00100;
  localparam logic [4:0] CLS_LOAD   = 5'b01000;
  localparam logic [4:0] CLS_BRANCH = 5'b10000;

  // Age of an entry is its position in the window, so it is not stored.
  typedef struct packed {
    logic       wr;
    logic [4:0] dst;
    logic       is_load;
  } entry_t;

  entry_t window_q [1:DEPTH];
  entry_t window_d [1:DEPTH];

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd;
  logic [5:0]      funct;
  logic [4:0]      cls;
  logic [4:0]      dst;
  logic            use_rs, use_rt, is_load;
  logic [FW_W-1:0] fwd_rs_k, fwd_rt_k;
  logic            rs_haz, rt_haz;
  logic            stall;
  logic            accept;

  // Field split.
  assign opcode = bus.ir[31:26];
  assign rs     = bus.ir[25:21];
  assign rt     = bus.ir[20:16];
  assign rd     = bus.ir[15:11];
  assign funct  = bus.ir[5:0];

  assign bus.opcode = opcode;
  assign bus.rs     = rs;
  assign bus.rt     = rt;
  assign bus.rd     = rd;
  assign bus.shamt  = bus.ir[10:6];
  assign bus.funct  = funct;

  // Classification, destination and source usage.
  always_comb begin
    // NOTE: every variable gets a default before the case so that opcodes
    // not listed leave no path that holds a previous value (no latch).
    cls     = '0;
    dst     = 5'd0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    is_load = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls    = CLS_ALUR;
        use_rs = 1'b1;
        if (funct != FN_JR) begin
          use_rt = 1'b1;
          dst    = rd;
        end
      end
      OP_ADDI, OP_ANDI, OP_XORI, OP_SLTIU: begin
        cls    = CLS_ALUIMM;
        use_rs = 1'b1;
        dst    = rt;
      end
      OP_LW: begin
        cls     = CLS_LOAD;
        use_rs  = 1'b1;
        dst     = rt;
        is_load = 1'b1;
      end
      OP_SW: begin
        cls    = CLS_STORE;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        cls    = CLS_BRANCH;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_JAL:  dst = 5'd31;
      default: ;
    endcase
  end

  assign bus.ins_class = cls;

  // Matching: scan oldest to youngest so the youngest match overwrites and
  // decides both the forward select and whether it is a load-use hazard.
  always_comb begin
    fwd_rs_k = '0;
    fwd_rt_k = '0;
    rs_haz   = 1'b0;
    rt_haz   = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (use_rs && rs != 5'd0 && window_q[k].wr && window_q[k].dst == rs) begin
        fwd_rs_k = FW_W'(k);
        rs_haz   = window_q[k].is_load && (k <= LOAD_LAT);
      end
      if (use_rt && rt != 5'd0 && window_q[k].wr && window_q[k].dst == rt) begin
        fwd_rt_k = FW_W'(k);
        rt_haz   = window_q[k].is_load && (k <= LOAD_LAT);
      end
    end
  end

  assign stall  = bus.id_valid && (rs_haz || rt_haz);
  assign accept = bus.id_valid && !stall && !bus.flush;

  assign bus.stall    = stall;
  assign bus.id_ready = !stall;
  assign bus.fwd_rs   = fwd_rs_k;
  assign bus.fwd_rt   = fwd_rt_k;

  // Window next state: shift toward DEPTH, insert the accepted instruction
  // or a bubble; a flush empties everything.
  always_comb begin
    for (int k = 1; k <= DEPTH; k++) window_d[k] = '0;
    if (!bus.flush) begin
      if (accept) begin
        window_d[1].wr      = (dst != 5'd0);
        window_d[1].dst     = dst;
        window_d[1].is_load = is_load;
      end
      for (int k = 2; k <= DEPTH; k++) window_d[k] = window_q[k-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the valid bits are reset; dst/is_load are ignored while
      // wr=0, so they need no reset value.
      for (int k = 1; k <= DEPTH; k++) window_q[k].wr <= 1'b0;
    end else begin
      window_q <= window_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, issue_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      if (stall && !bus.flush && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (accept && issue_cnt_q != 32'hFFFF_FFFF)
        issue_cnt_q <= issue_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.issue_cnt = issue_cnt_q;
`endif

endmodule

// File: doc/ins_hazard_tracker.md
# ins_hazard_tracker

Parametrised decode, classification and hazard-tracking stage for the MIPS-subset pipelined CPU. It accepts an instruction word at the ID stage, splits it into fields, and classifies it. It keeps a shift window of the last DEPTH issued instructions' destination registers and, from that window, produces per-source forwarding selects and a load-use stall with a ready/valid handshake toward fetch. Branch flushes clear the window.

## Interface
Parameters:
- DEPTH, 3: in-flight entries tracked after ID (EX..WB); legal range ≥1.
- LOAD_LAT, 1: extra cycles before a load result can be forwarded; legal range 1..DEPTH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  IR holds a valid instruction.
- id_ready  out  1  instruction accepted this cycle; equals !stall.
- ir  in  32  instruction word.
- flush  in  1  clear all in-flight entries (branch/jump redirect).
- opcode, rs, rt, rd, shamt, funct  out  6/5/5/5/5/6  combinational field split of ir.
- ins_class  out  5  one-hot {ALUImm, ALUR, Store, Load, Branch}; all zero for J/JAL/unknown.
- fwd_rs, fwd_rt  out  $clog2(DEPTH+1)  0 = register file; k = forward from entry k.
- stall  out  1  load-use hazard; bubble inserted.
- stall_cnt, issue_cnt  out  32  statistics; present only with HAZARD_STATS_EN.

## Operation
- Classes: Branch = opcode 000100/000101; Load = 100011; Store = 101011; ALUR = 000000; ALUImm = 001000/001100/001110/001011.
- Destination: ALUR writes rd, except funct 001000 (jr). ALUImm and Load write rt. JAL (000011) writes 31. Store, Branch and J write nothing. A destination of 0 is recorded as no write.
- Sources used:
  - ALUR: rs and rt (jr: rs only).
  - ALUImm, Load: rs.
  - Store, Branch: rs and rt.
  - J, JAL: none.
  - Unused sources and register 0 never match.
- Window entry k (1..DEPTH) = {wr, dst, is_load, age}. Entry 1 is the instruction issued on the previous cycle.
- Every cycle the window shifts toward DEPTH and the oldest entry drops out. The new entry 1 is:
  - the accepted instruction when id_valid && id_ready && !flush;
  - otherwise a bubble (wr=0).
- Matching: for each used source, the youngest entry k with wr && dst==src decides. Only the youngest match matters; older entries are ignored.
- Forwarding: fwd = k of that match, or 0 if there is none.
- Load-use: if the deciding entry has is_load && k ≤ LOAD_LAT and id_valid=1, then stall=1. While stalling, fwd outputs are don't-care.
- flush=1: next cycle all entries are invalid and the current instruction is not inserted. flush overrides issue and stall.
- Unknown opcodes: classified all zero, no destination, no sources; accepted normally.

## Timing
- Field split, ins_class, fwd_*, stall and id_ready are combinational from ir and the current window.
- Window update latency is 1 cycle: an instruction accepted at edge t is entry 1 during cycle t+1 and entry k during cycle t+k.
- A stall of a load at distance 1 with LOAD_LAT=1 lasts exactly 1 cycle. In general the stall lasts LOAD_LAT−k+1 cycles.
- Reset: window entries are all invalid, so after reset stall=0, id_ready=1, fwd_rs=fwd_rt=0, and counters are 0.
- Reset mid-stall: the stall releases on the next cycle.
- Simultaneous rst and flush: rst dominates; the result is identical (empty window).

## Configuration
- HAZARD_STATS_EN defined:
  - stall_cnt increments every cycle with stall=1 && !flush.
  - issue_cnt increments on every accepted instruction.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- HAZARD_STATS_EN undefined: the counter ports and their logic are absent from the module.

## Test plan
- Reset, then idle: stall=0, id_ready=1, fwd_rs=fwd_rt=0, and all window entries invalid for ≥DEPTH cycles.
- Load-use stall (DEPTH=3, LOAD_LAT=1): issue lw $8,0($9) (0x8D280000), then present add $10,$8,$11 (0x010B5020).
  - Required: stall=1 for exactly 1 cycle.
  - Then accepted with fwd_rs=2, fwd_rt=0, ins_class=00010.
- ALU forwarding: addi $8,$0,5 (0x20080005) then 0x010B5020 back-to-back → no stall, fwd_rs=1.
  - With one bubble between them: fwd_rs=2.
  - With three bubbles: fwd_rs=0.
- Register zero: addi $0,$0,1 (0x20000001) then add $10,$0,$0 (0x00005020) → fwd_rs=fwd_rt=0, stall=0.
- Youngest match wins: lw $8 (0x8D280000), then addi $8,$0,5, then 0x010B5020 → no stall, fwd_rs=1.
- Flush during stall: lw $8 then 0x010B5020 with flush=1 in the stall cycle.
  - Next cycle: window empty, stall=0, fwd_rs=0.
  - With HAZARD_STATS_EN: stall_cnt unchanged by that cycle and issue_cnt=1.
